serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Initiator side of the bit-serial full-adder cell interface (start, rst, CIN, A, B -> S, COUT).
- Accepts two WIDTH-bit operands in parallel and streams them LSB-first into the adder cell.
- Feeds each returned COUT back as the next CIN and shifts each returned S into a parallel result.
- Sits between a parallel requester and the adder cell and owns all of the cell's control inputs.

Parameters:
- WIDTH, 8, operand and result width in bits (2..32)
- CW, 6, bit-counter width; must satisfy 2**CW > WIDTH

Ports:
- CLK  in  1  single clock, rising edge
- NRST  in  1  asynchronous active-low reset
- req  in  1  request pulse; sampled only in IDLE
- opa  in  WIDTH  operand A, captured when req is accepted
- opb  in  WIDTH  operand B, captured when req is accepted
- cin_init  in  1  carry-in for bit 0, captured when req is accepted
- abort  in  1  synchronous abort
- busy  out  1  high from acceptance until DONE is left
- done  out  1  one-cycle pulse; sum and carry_out are valid from this cycle
- sum  out  WIDTH  result, held until the next acceptance
- carry_out  out  1  final carry, held until the next acceptance
- start  out  1  adder cell start, pulsed one cycle per operation
- rst  out  1  adder cell synchronous clear
- A  out  1  current bit of operand A
- B  out  1  current bit of operand B
- CIN  out  1  current carry-in
- S  in  1  adder cell sum, registered in the cell
- COUT  in  1  adder cell carry, registered in the cell

Behaviour:
- Reset (NRST=0, asynchronous):
  - state=IDLE, counter=0, shift registers=0
  - busy=0, done=0, sum=0, carry_out=0, start=0, A=0, B=0, CIN=0
  - rst=1; rst is the only output that is 1 in reset.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ARM, DRIVE, CAPTURE, DONE. Encoding lives in the package.
- IDLE:
  - rst=1.
  - If req=1: load opa/opb into shift registers, load cin_init into the carry register, clear counter and result shift register, set busy=1, go to ARM.
  - Accepting req requires no additional condition; req in any other state is ignored, not queued.
- ARM (1 cycle): rst=0, start=1, go to DRIVE.
- DRIVE (1 cycle):
  - start=0, A=opa_sr[0], B=opb_sr[0], CIN=carry register.
  - Go to CAPTURE.
- CAPTURE (1 cycle):
  - The cell's registered S/COUT for the bit driven in DRIVE are valid this cycle.
  - Shift S into the MSB of the result register, right-shifting the previous contents.
  - Load COUT into the carry register. Shift opa_sr/opb_sr right by one and increment the counter.
  - If counter==WIDTH-1: go to DONE. Otherwise go to DRIVE.
- Slot timing: 2 cycles per bit. Latency from req-accept to done is 1+2*WIDTH+1 cycles (18 for WIDTH=8).
- DONE (1 cycle):
  - sum <= result register, carry_out <= carry register, done=1.
  - Then go to IDLE; busy=0 in the cycle after done.
- Outputs while not driving: A, B and CIN hold 0 in every state except DRIVE/CAPTURE. They hold the DRIVE values through CAPTURE.
- abort=1 in any state except IDLE:
  - Next cycle: IDLE, rst=1, busy=0, done stays 0.
  - sum and carry_out keep their previous values.
  - abort has priority over the CAPTURE->DONE transition.
- abort in IDLE has no effect. abort and req high together in IDLE: req is accepted.
- NRST deasserted mid-operation: the operation is lost; no done pulse.
- Arithmetic: {carry_out,sum} = opa + opb + cin_init, modulo 2**(WIDTH+1).

Decomposition:
- Package serial_add_pkg:
  - state enum typedef
  - SLOT_CYCLES=2
  - latency function lat(WIDTH)=2*WIDTH+2
- One natural sub-module, serial_add_shreg: a parameterised load/shift-right register, instantiated three times (opa, opb, result).

Test Plan:
- opa=8'h35, opb=8'h4A, cin_init=0 -> done 18 cycles after accept; sum=8'h7F, carry_out=0. The A stream in DRIVE cycles is 1,0,1,0,1,1,0,0.
- opa=8'hFF, opb=8'h01, cin_init=0 -> sum=8'h00, carry_out=1. CIN=1 on bits 1..7.
- opa=8'hFF, opb=8'hFF, cin_init=1 -> sum=8'hFF, carry_out=1. Then a back-to-back req in the cycle after done is accepted from IDLE.
- abort asserted in the CAPTURE of bit 4 of opa=8'h0F, opb=8'h0F -> IDLE next cycle, rst=1, no done, sum keeps its old value. A following req for 8'h0F+8'h0F gives 8'h1E.
- NRST pulsed low mid-DRIVE -> all outputs return immediately (asynchronously) to reset values, with rst=1. Stray req pulses while busy are ignored, and only one done occurs per accepted req.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    // Controller sequence: one ARM cycle, then a DRIVE/CAPTURE pair per bit.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Cycles spent on each operand bit (drive, then capture).
    localparam int SLOT_CYCLES = 2;

    // Cycles from request acceptance to the done pulse.
    function automatic int lat(input int width);
        return SLOT_CYCLES * width + 2;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side and adder-cell-side signals of the serial adder controller.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    // Parallel requester side
    logic             req;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             cin_init;
    logic             abort;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;

    // Bit-serial adder cell side
    logic             start;
    logic             rst;
    logic             A;
    logic             B;
    logic             CIN;
    logic             S;
    logic             COUT;

    // Controller view
    modport master (
        input  req, opa, opb, cin_init, abort, S, COUT,
        output busy, done, sum, carry_out, start, rst, A, B, CIN
    );

    // Environment view (requester plus adder cell)
    modport slave (
        output req, opa, opb, cin_init, abort, S, COUT,
        input  busy, done, sum, carry_out, start, rst, A, B, CIN
    );

endinterface

// File: rtl/serial_add_shreg.sv
// Parallel-load, right-shift register; load takes priority over shift.
module serial_add_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         shift_i,
    input  logic         shift_in_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next value: parallel load, else shift right with new bit entering the MSB.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = load_val_i;
        end else if (shift_i) begin
            q_d = {shift_in_i, q_q[W-1:1]};
        end
    end

    // Register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Initiator for a bit-serial full-adder cell: streams two parallel operands
// LSB-first into the cell, recirculates the carry and assembles the sum.
// Every output is a flop; output flops are loaded from the next state so
// they line up with the state they belong to.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input logic               CLK,
    input logic               NRST,
    serial_add_ctrl_if.master sa
);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic             rst_q, rst_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic             accept;
    logic             advance;
    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] res_sr;

    // Operand A, operand B and result shift registers.
    serial_add_shreg #(.W(WIDTH)) u_opa_sr (
        .clk_i      (CLK),
        .rst_n_i    (NRST),
        .load_i     (accept),
        .load_val_i (sa.opa),
        .shift_i    (advance),
        .shift_in_i (1'b0),
        .q_o        (opa_sr)
    );

    serial_add_shreg #(.W(WIDTH)) u_opb_sr (
        .clk_i      (CLK),
        .rst_n_i    (NRST),
        .load_i     (accept),
        .load_val_i (sa.opb),
        .shift_i    (advance),
        .shift_in_i (1'b0),
        .q_o        (opb_sr)
    );

    serial_add_shreg #(.W(WIDTH)) u_res_sr (
        .clk_i      (CLK),
        .rst_n_i    (NRST),
        .load_i     (accept),
        .load_val_i ({WIDTH{1'b0}}),
        .shift_i    (advance),
        .shift_in_i (sa.S),
        .q_o        (res_sr)
    );

    // Upper operand bits are only consumed through the shift path and the
    // oldest result bit falls off on the final shift.
    logic unused_bits;
    assign unused_bits = ^{opa_sr, opb_sr, res_sr[0]};

    // Next-state and next-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        cin_d   = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        accept  = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sa.req) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    carry_d = sa.cin_init;
                    busy_d  = 1'b1;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                // Present bit 0 for the first DRIVE cycle.
                a_d     = opa_sr[0];
                b_d     = opb_sr[0];
                cin_d   = carry_q;
                state_d = ST_DRIVE;
            end
            ST_DRIVE: begin
                // Hold the driven bit through CAPTURE.
                a_d     = a_q;
                b_d     = b_q;
                cin_d   = cin_q;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                advance = 1'b1;
                carry_d = sa.COUT;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    // Publish the fully shifted result together with done.
                    done_d  = 1'b1;
                    sum_d   = {sa.S, res_sr[WIDTH-1:1]};
                    cout_d  = sa.COUT;
                    state_d = ST_DONE;
                end else begin
                    // Bit 1 of the pre-shift operand is bit 0 after this edge.
                    a_d     = opa_sr[1];
                    b_d     = opb_sr[1];
                    cin_d   = sa.COUT;
                    state_d = ST_DRIVE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        if (sa.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            a_d     = 1'b0;
            b_d     = 1'b0;
            cin_d   = 1'b0;
            sum_d   = sum_q;
            cout_d  = cout_q;
            carry_d = carry_q;
            cnt_d   = cnt_q;
            advance = 1'b0;
        end

        start_d = (state_d == ST_ARM);
        rst_d   = (state_d == ST_IDLE);
    end

    // State, counter, carry and output registers.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            start_q <= 1'b0;
            rst_q   <= 1'b1;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            start_q <= start_d;
            rst_q   <= rst_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sa.busy      = busy_q;
    assign sa.done      = done_q;
    assign sa.sum       = sum_q;
    assign sa.carry_out = cout_q;
    assign sa.start     = start_q;
    assign sa.rst       = rst_q;
    assign sa.A         = a_q;
    assign sa.B         = b_q;
    assign sa.CIN       = cin_q;

endmodule
